// File: rtl/br_train_queue.sv
// In-order branch training queue: holds the fetch-time BTB prediction per branch,
// captures the execute outcome, and emits the BTB training bundle when the head commits.
module br_train_queue #(
  parameter int ADDR    = 32,
  parameter int QUEUE_D = 8,
  parameter int QIDX    = $clog2(QUEUE_D)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            enq_,
  input  logic [ADDR-1:0] enq_pc,
  input  logic            enq_pred_taken,
  input  logic [ADDR-1:0] enq_pred_tar,
  output logic [QIDX-1:0] enq_tag,
  output logic            full,
  input  logic            res_,
  input  logic [QIDX-1:0] res_tag,
  input  logic            res_taken,
  input  logic [ADDR-1:0] res_tar,
  input  logic            com_,
  output logic            com_ready,
  input  logic            flush_,
  output logic            pc_chg_com_,
  output logic            chg_taken_,
  output logic            target_miss_,
  output logic [ADDR-1:0] com_addr,
  output logic [ADDR-1:0] com_tar_addr,
  output logic            mispred_
);

  localparam logic [QIDX:0] CNT_FULL = (QIDX+1)'(QUEUE_D);

  logic [QUEUE_D-1:0] r_valid;
  logic [QUEUE_D-1:0] r_resolved;
  logic [QUEUE_D-1:0] r_pred_taken;
  logic [QUEUE_D-1:0] r_act_taken;
  logic [ADDR-1:0]    r_pc       [QUEUE_D];
  logic [ADDR-1:0]    r_pred_tar [QUEUE_D];
  logic [ADDR-1:0]    r_act_tar  [QUEUE_D];
  logic [QIDX-1:0]    r_head;
  logic [QIDX-1:0]    r_tail;
  logic [QIDX:0]      r_count;
  logic               r_full;
  logic               r_com_ready;
  logic               r_pc_chg_com_;
  logic               r_chg_taken_;
  logic               r_target_miss_;
  logic               r_mispred_;
  logic [ADDR-1:0]    r_com_addr;
  logic [ADDR-1:0]    r_com_tar_addr;

  logic               w_enq_acc;
  logic               w_res_acc;
  logic               w_com_acc;
  logic [QUEUE_D-1:0] w_valid_nxt;
  logic [QUEUE_D-1:0] w_resolved_nxt;
  logic [QIDX-1:0]    w_head_nxt;
  logic [QIDX-1:0]    w_tail_nxt;
  logic [QIDX:0]      w_count_nxt;
  logic               w_ready_nxt;
  logic               w_tgt_miss;
  logic               w_mispred;

  // Flush discards same-cycle enqueue/resolve, but a commit accepted this cycle still retires.
  assign w_enq_acc = ~enq_ & ~r_full & flush_;
  assign w_res_acc = ~res_ & r_valid[res_tag] & flush_;
  assign w_com_acc = ~com_ & r_com_ready;

  for (genvar i = 0; i < QUEUE_D; i++) begin : g_slot
    assign w_valid_nxt[i] = flush_ &
        ((r_valid[i] & ~(w_com_acc & (r_head == QIDX'(i)))) |
         (w_enq_acc & (r_tail == QIDX'(i))));
    assign w_resolved_nxt[i] = flush_ &
        ~(w_com_acc & (r_head == QIDX'(i))) &
        ~(w_enq_acc & (r_tail == QIDX'(i))) &
        (r_resolved[i] | (w_res_acc & (res_tag == QIDX'(i))));
  end

  assign w_head_nxt  = flush_ ? (r_head + QIDX'(w_com_acc)) : '0;
  assign w_tail_nxt  = flush_ ? (r_tail + QIDX'(w_enq_acc)) : '0;
  assign w_count_nxt = flush_ ? (r_count + (QIDX+1)'(w_enq_acc) - (QIDX+1)'(w_com_acc)) : '0;
  // com_ready looks at the head as it will be after this cycle's updates.
  assign w_ready_nxt = w_valid_nxt[w_head_nxt] & w_resolved_nxt[w_head_nxt];

  assign w_tgt_miss = r_act_taken[r_head] &
      (~r_pred_taken[r_head] | (r_pred_tar[r_head] != r_act_tar[r_head]));
  assign w_mispred  = (r_pred_taken[r_head] != r_act_taken[r_head]) | w_tgt_miss;

  // Queue state, pointers and the registered training bundle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_valid        <= '0;
      r_resolved     <= '0;
      r_pred_taken   <= '0;
      r_act_taken    <= '0;
      for (int i = 0; i < QUEUE_D; i++) begin
        r_pc[i]       <= '0;
        r_pred_tar[i] <= '0;
        r_act_tar[i]  <= '0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_com_ready    <= 1'b0;
      r_pc_chg_com_  <= 1'b1;
      r_chg_taken_   <= 1'b1;
      r_target_miss_ <= 1'b1;
      r_mispred_     <= 1'b1;
      r_com_addr     <= '0;
      r_com_tar_addr <= '0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_resolved  <= w_resolved_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CNT_FULL);
      r_com_ready <= w_ready_nxt;
      if (w_enq_acc) begin
        r_pc[r_tail]         <= enq_pc;
        r_pred_taken[r_tail] <= enq_pred_taken;
        r_pred_tar[r_tail]   <= enq_pred_tar;
      end
      if (w_res_acc) begin
        r_act_taken[res_tag] <= res_taken;
        r_act_tar[res_tag]   <= res_tar;
      end
      r_pc_chg_com_  <= 1'b1;
      r_chg_taken_   <= 1'b1;
      r_target_miss_ <= 1'b1;
      r_mispred_     <= 1'b1;
      if (w_com_acc) begin
        r_pc_chg_com_  <= 1'b0;
        r_chg_taken_   <= ~r_act_taken[r_head];
        r_target_miss_ <= ~w_tgt_miss;
        r_mispred_     <= ~w_mispred;
        r_com_addr     <= r_pc[r_head];
        r_com_tar_addr <= r_act_tar[r_head];
      end
    end
  end

  assign enq_tag      = r_tail;
  assign full         = r_full;
  assign com_ready    = r_com_ready;
  assign pc_chg_com_  = r_pc_chg_com_;
  assign chg_taken_   = r_chg_taken_;
  assign target_miss_ = r_target_miss_;
  assign mispred_     = r_mispred_;
  assign com_addr     = r_com_addr;
  assign com_tar_addr = r_com_tar_addr;

endmodule
